// File: rtl/serial_word_rx.sv
// Serial-in/parallel-out word receiver for an MSB-first stream with an optional trailing even-parity bit.
// state | meaning
// IDLE  | waiting for a START-qualified first bit
// DATA  | collecting data bits, cnt holds the number already taken
// PARB  | all data bits in, waiting for the parity bit
module serial_word_rx #(
  parameter int W      = 4,
  parameter int PARITY = 0
) (
  input  logic         clk,
  input  logic         CLR,
  input  logic         SIN,
  input  logic         SEN,
  input  logic         START,
  output logic [W-1:0] DOUT,
  output logic         DVALID,
  output logic         PERR,
  output logic         FERR,
  output logic         BUSY
);

  localparam int CW      = $clog2(W + 1);
  localparam bit HAS_PAR = (PARITY != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PARB = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_shift;
  logic [CW-1:0] cnt;
  logic          par;

  logic          take_start;
  logic          take_bit;
  logic          shift_data;
  logic          last_data;
  logic          finish;
  logic          abort;

  assign take_start = SEN & START;
  assign take_bit   = SEN & ~START;
  assign sr_shift   = {sr[W-2:0], SIN};

  always_ff @(posedge clk) begin
    if (CLR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_start) state_nxt = DATA;
      end
      DATA: begin
        if (take_start) begin
          state_nxt = DATA;
        end else if (take_bit && (cnt == CW'(W - 1))) begin
          state_nxt = HAS_PAR ? PARB : IDLE;
        end
      end
      PARB: begin
        if (take_start) begin
          state_nxt = DATA;
        end else if (take_bit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes for the datapath; a START in any state always begins a new frame.
  always_comb begin
    shift_data = 1'b0;
    last_data  = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    BUSY       = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
      end
      DATA: begin
        BUSY       = 1'b1;
        abort      = take_start;
        shift_data = take_bit;
        last_data  = take_bit && (cnt == CW'(W - 1));
        finish     = last_data && !HAS_PAR;
      end
      PARB: begin
        BUSY   = 1'b1;
        abort  = take_start;
        finish = take_bit;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      sr     <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      DOUT   <= '0;
      DVALID <= 1'b0;
      PERR   <= 1'b0;
      FERR   <= 1'b0;
    end else begin
      DVALID <= finish;
      FERR   <= abort;
      if (take_start) begin
        sr  <= {{(W-1){1'b0}}, SIN};
        par <= SIN;
        cnt <= CW'(1);
      end else if (shift_data) begin
        sr  <= sr_shift;
        par <= par ^ SIN;
        cnt <= cnt + CW'(1);
      end
      // In PARB the data word is already complete in sr; SIN is the parity bit.
      if (finish) begin
        if (state == PARB) begin
          DOUT <= sr;
          PERR <= par ^ SIN;
        end else begin
          DOUT <= sr_shift;
          PERR <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Drives two receivers (no parity / even parity) with one shared serial stream and
// compares every output each cycle against a bit-counting reference model.
module tb_serial_word_rx;

  localparam int W = 4;

  logic         clk;
  logic         clr;
  logic         sin;
  logic         sen;
  logic         start;

  logic [W-1:0] dout0, dout1;
  logic         dvalid0, dvalid1;
  logic         perr0, perr1;
  logic         ferr0, ferr1;
  logic         busy0, busy1;

  int n_vec;
  int n_err;
  int cyc;

  // reference model state, index = PARITY setting
  bit       m_in   [2];
  int       m_n    [2];
  int       m_acc  [2];
  int       m_ones [2];
  logic [W-1:0] m_dout [2];
  bit       m_dv   [2];
  bit       m_perr [2];
  bit       m_ferr [2];

  serial_word_rx #(.W(W), .PARITY(0)) u_rx0 (
    .clk(clk), .CLR(clr), .SIN(sin), .SEN(sen), .START(start),
    .DOUT(dout0), .DVALID(dvalid0), .PERR(perr0), .FERR(ferr0), .BUSY(busy0)
  );

  serial_word_rx #(.W(W), .PARITY(1)) u_rx1 (
    .clk(clk), .CLR(clr), .SIN(sin), .SEN(sen), .START(start),
    .DOUT(dout1), .DVALID(dvalid1), .PERR(perr1), .FERR(ferr1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // A frame is W data bits (+1 parity bit); the word is the data bits read MSB first.
  task automatic mdl(input int p);
    int nbits;
    nbits = W + p;
    m_dv[p]   = 1'b0;
    m_ferr[p] = 1'b0;
    if (clr) begin
      m_in[p] = 1'b0; m_n[p] = 0; m_acc[p] = 0; m_ones[p] = 0;
      m_dout[p] = '0; m_perr[p] = 1'b0;
    end else if (sen) begin
      if (start) begin
        m_ferr[p] = m_in[p];
        m_in[p]   = 1'b1;
        m_n[p]    = 1;
        m_acc[p]  = int'(sin);
        m_ones[p] = int'(sin);
      end else if (m_in[p]) begin
        if (m_n[p] < W) m_acc[p] = m_acc[p] * 2 + int'(sin);
        m_ones[p] = m_ones[p] + int'(sin);
        m_n[p]    = m_n[p] + 1;
        if (m_n[p] == nbits) begin
          m_dout[p] = W'(m_acc[p]);
          m_perr[p] = (p == 1) && (m_ones[p] % 2 == 1);
          m_dv[p]   = 1'b1;
          m_in[p]   = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("dout0",   32'(dout0),   32'(m_dout[0]));
    chk("dvalid0", 32'(dvalid0), 32'(m_dv[0]));
    chk("perr0",   32'(perr0),   32'(m_perr[0]));
    chk("ferr0",   32'(ferr0),   32'(m_ferr[0]));
    chk("busy0",   32'(busy0),   32'(m_in[0]));
    chk("dout1",   32'(dout1),   32'(m_dout[1]));
    chk("dvalid1", 32'(dvalid1), 32'(m_dv[1]));
    chk("perr1",   32'(perr1),   32'(m_perr[1]));
    chk("ferr1",   32'(ferr1),   32'(m_ferr[1]));
    chk("busy1",   32'(busy1),   32'(m_in[1]));
  endtask

  task automatic step(input logic c, input logic e, input logic s, input logic d);
    clr = c; sen = e; start = s; sin = d;
    @(posedge clk);
    cyc++;
    mdl(0);
    mdl(1);
    #1;
    check_all();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  int t_first;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    clr = 1'b1; sen = 1'b0; start = 1'b0; sin = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_in[p] = 0; m_n[p] = 0; m_acc[p] = 0; m_ones[p] = 0;
      m_dout[p] = '0; m_dv[p] = 0; m_perr[p] = 0; m_ferr[p] = 0;
    end

    // reset held two cycles
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_dout0", 32'(dout0), 0);
    chk("rst_busy1", 32'(busy1), 0);

    // 1011, consecutive bits
    step(0, 1, 1, 1); step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 1);
    chk("w1011_dout0", 32'(dout0), 32'hB);
    chk("w1011_dv0", 32'(dvalid0), 1);
    step(0, 0, 0, 0);
    chk("w1011_dv0_clr", 32'(dvalid0), 0);
    step(0, 1, 0, 0); // parity bit for the PARITY=1 receiver

    // 0110 with SEN gaps
    step(0, 1, 1, 0); gap(1); step(0, 1, 0, 1); gap(3); step(0, 1, 0, 1); gap(2); step(0, 1, 0, 0);
    chk("w0110_dout0", 32'(dout0), 32'h6);
    gap(2); step(0, 1, 0, 0);

    // 1101 with good then bad parity
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 1);
    chk("par_ok_dout1", 32'(dout1), 32'hD);
    chk("par_ok_perr1", 32'(perr1), 0);
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 0);
    chk("par_bad_perr1", 32'(perr1), 1);

    // abort by restart
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 1, 0);
    chk("abort_ferr0", 32'(ferr0), 1);
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 1);
    chk("abort_dout0", 32'(dout0), 32'h3);
    step(0, 1, 0, 0);

    // CLR mid-frame, then back-to-back frames
    step(0, 1, 1, 1); step(0, 1, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 1, 1); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 1);
    chk("b2b_dout0", 32'(dout0), 32'h9);
    t_first = cyc;
    step(0, 1, 1, 0); step(0, 1, 0, 1); step(0, 1, 0, 0); step(0, 1, 0, 1);
    chk("b2b_dout0b", 32'(dout0), 32'h5);
    chk("b2b_spacing", 32'(cyc - t_first), 4);
    step(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 70),
           1'($urandom_range(0, 99) < 12), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Serial-in/parallel-out word receiver. It is the receive end of the MSB-first serial stream produced by the left-shifting universal shift register (QA out, LIN fill).
- It captures W data bits plus an optional even-parity bit and presents the word in parallel with a one-cycle valid strobe.
- It flags parity and framing errors and sits between the serial link and the parallel consumer logic.

Parameters:
W, 4, data bits per frame (W >= 2)
PARITY, 0, 1 = one even-parity bit follows the data bits; 0 = no parity bit

Ports:
clk  input  1  single system clock; all state updates on rising edge
CLR  input  1  synchronous, active-high reset
SIN  input  1  serial data bit, sampled only when SEN=1
SEN  input  1  bit-valid/shift enable; SEN=0 means hold (no shift, no count)
START  input  1  frame-start marker; qualified by SEN; marks SIN as the first (MSB) bit
DOUT  output  W  received word, first-received bit in DOUT[W-1]
DVALID  output  1  one-cycle pulse: DOUT holds a new complete frame
PERR  output  1  parity error for the frame reported with DVALID; 0 when PARITY=0
FERR  output  1  one-cycle pulse: a frame was aborted by a new START
BUSY  output  1  1 while a frame is in progress (state != IDLE)

Behaviour:
- Reset: when CLR=1 at a rising edge, the block clears everything. State=IDLE; shift register=0; bit count=0; DOUT=0; DVALID=0; PERR=0; FERR=0; BUSY=0. CLR overrides all other inputs, including mid-frame, and any partial frame is discarded silently (no FERR).
- Internal state: a W-bit shift register `sr`, a bit counter `cnt` (0..W), and a running parity bit `par`.
- Shift rule: on each accepted bit, `sr` <= {sr[W-2:0], SIN} and `par` <= par ^ SIN. This is the left shift, matching the transmitter's output order.
- States: IDLE, DATA, PARB.
- IDLE: SEN=1 & START=1 accepts SIN as the MSB. Set sr={0..,SIN}, par=SIN, cnt=1, then go to DATA. Any other input leaves the block idle. SEN=1 & START=0 bits are ignored.
- DATA: SEN=1 & START=0 shifts SIN in and increments cnt.
  - When the accepted bit makes cnt=W with PARITY=0: DOUT <= shifted word, DVALID=1 on the next cycle, PERR=0, state returns to IDLE.
  - When the accepted bit makes cnt=W with PARITY=1: go to PARB; no output change.
- PARB: SEN=1 & START=0 takes SIN as the parity bit. DOUT <= sr, DVALID=1 on the next cycle, PERR <= par ^ SIN (1 means odd total), then return to IDLE.
- SEN=0 in any state: full hold. sr, cnt, par, state and DOUT are all unchanged.
- Restart: SEN=1 & START=1 while in DATA or PARB aborts the current frame. FERR=1 for exactly one cycle. The same cycle's SIN becomes the MSB of the new frame (cnt=1, state DATA). No DVALID is issued for the aborted frame.
- Latency: DVALID/DOUT are registered and visible in the cycle after the edge that samples the final bit (last data bit, or the parity bit when PARITY=1).
- Back-to-back frames: a START with SEN in the cycle immediately after the final bit is legal. The next frame starts with no idle gap. DVALID for the previous frame and acceptance of the new MSB coincide.
- DVALID and FERR are single-cycle pulses, cleared on the next edge.
- DOUT and PERR hold their last values until the next completed frame.
- BUSY=1 in DATA and PARB, 0 in IDLE.

Test Plan:
- Reset, then CLR held 2 cycles: every output must be 0 and BUSY=0.
- W=4, PARITY=0; send START+1, 0, 1, 1 on consecutive SEN cycles -> one cycle later DOUT=4'b1011, DVALID=1 for exactly one cycle, PERR=0, BUSY returns to 0.
- W=4, PARITY=0; send 0, 1, 1, 0 with SEN=0 gaps of 1–3 cycles between bits -> DOUT=4'b0110 with a single DVALID. Nothing changes during the gaps.
- W=4, PARITY=1:
  - Send 1, 1, 0, 1 then parity bit 1 -> DOUT=4'b1101, PERR=0.
  - Repeat with parity bit 0 -> DOUT=4'b1101, PERR=1.
- W=4; send START+1, 1, then START+0, 0, 1, 1 -> FERR pulses once at the second START, with no DVALID for the first frame. Then DOUT=4'b0011 with DVALID.
- Frame interrupted: send 2 bits, assert CLR for 1 cycle, then send a full frame 1,0,0,1 -> no FERR, no DVALID before the new frame, then DOUT=4'b1001. Back-to-back: a second frame 0,1,0,1 started the cycle right after -> two DVALID pulses exactly 4 cycles apart.
